mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
Parametrised memory stage for the pipelined CPU. It sits between execute and writeback and replaces the pass-through stage. It issues load/store requests on the data bus with byte strobes and holds the request until the bus completes. Load data is aligned and sign/zero-extended before it is presented to writeback through a single-entry valid/ready output register.

Parameters:
XLEN, 64, datapath width in bits (32 or 64); also the address and PC width.
REG_W, 5, destination register index width.
OFF_W, $clog2(XLEN/8), byte-offset bits within one bus word (derived; not overridable).

Ports:
clk  input  1  clock, rising edge
resetn  input  1  asynchronous active-low reset
flush  input  1  squash the in-flight and incoming instruction
in_valid  input  1  execute presents an instruction
in_ready  output  1  stage accepts this cycle
in_pc  input  XLEN  instruction PC
in_addr  input  XLEN  ALU result / effective address
in_wdata  input  XLEN  store data, unshifted
in_is_load  input  1  load op
in_is_store  input  1  store op
in_size  input  2  0=byte, 1=half, 2=word, 3=dword (dword legal only when XLEN=64)
in_unsigned  input  1  zero-extend load
in_dst  input  REG_W  destination register
dreq_valid  output  1  bus request
dreq_addr  output  XLEN  request address
dreq_size  output  2  request size
dreq_strobe  output  XLEN/8  byte write enables; all 0 for loads
dreq_data  output  XLEN  store data shifted into lane position
dresp_data_ok  input  1  bus completion, one-cycle pulse
dresp_data  input  XLEN  read data, full bus word
out_valid  output  1  writeback entry valid
out_ready  input  1  writeback accepts
out_pc  output  XLEN  PC
out_dst  output  REG_W  destination
out_result  output  XLEN  loaded value, or in_addr for ALU ops and stores
out_is_load  output  1  entry was a load

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE; out_valid=0; dreq_valid=0; all data outputs 0.
- States: IDLE, BUSY (request outstanding), DRAIN (request outstanding, result to be discarded).
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- Accept of a non-memory op in IDLE: out_valid=1 next cycle, out_result=in_addr. Latency is 1 cycle.
- Accept of a load/store in IDLE: next cycle state=BUSY with dreq_valid=1.
  - Request fields are registered and held stable until dresp_data_ok.
  - dreq_addr = in_addr; dreq_size = in_size.
  - Offset off = addr[OFF_W-1:0]; dreq_strobe = ((1<<(1<<size))-1) << off for stores.
  - dreq_data = wdata << (8*off).
- BUSY with dresp_data_ok:
  - Load: out_result = extend((dresp_data >> 8*off) truncated to size). Sign or zero extension is selected by in_unsigned.
  - Store: out_result = addr.
  - In both cases out_valid=1 and state=IDLE in the same edge. Minimum load-to-output latency is 2 cycles when data_ok arrives in the first BUSY cycle.
- dresp_data_ok in IDLE is ignored.
- Output hold: out_valid stays 1 and out_* stay stable until out_ready. A new entry may be written on the same edge the old one is consumed.
- flush in IDLE: out_valid cleared next edge; no accept.
- flush in BUSY: go to DRAIN. dreq_valid stays asserted with unchanged fields, because the bus cannot be aborted. On data_ok, go to IDLE with out_valid=0.
- flush in DRAIN: no effect.
- flush and in_valid in the same cycle: the input is not accepted.
- XLEN=32 with size=3: treated as size=2.
- Misaligned access (addr not a multiple of 1<<size) without the optional feature: the offset bits below the size alignment are cleared before issue. Example: half at 0x3 is issued as 0x2.

Optional Feature:
MEM_MISALIGN_TRAP_EN
- Defined:
  - Adds output port out_misalign (1).
  - A misaligned load/store issues no bus request.
  - Produces out_valid=1 one cycle after accept, with out_misalign=1 and out_result=in_addr.
  - out_misalign=0 for all other entries; reset value 0.
- Undefined: the port is absent and the align-down rule above applies.

Test Plan:
- XLEN=64, load byte signed, addr 0x1003, dresp_data=0x00000000_80000000, data_ok after 2 cycles -> dreq_strobe=0x00, out_result=0xFFFFFFFF_FFFFFF80, out_valid 1 cycle after data_ok edge.
- Store half addr 0x1006, wdata 0xBEEF -> dreq_strobe=0xC0, dreq_data=0xBEEF<<48, request held stable 3 cycles until data_ok, out_result=0x1006.
- ALU op while out_ready=0 for 4 cycles -> out_valid held, out_result unchanged, in_ready=0. Releasing out_ready with a new in_valid accepts back-to-back with no bubble.
- Load issued, flush asserted in BUSY, data_ok 2 cycles later -> dreq_valid held until data_ok, out_valid never asserts, in_ready returns 1 the cycle after data_ok.
- resetn pulsed low mid-BUSY -> dreq_valid and out_valid drop immediately (asynchronously), state IDLE.
- With MEM_MISALIGN_TRAP_EN: load word at 0x1002 -> dreq_valid stays 0, out_misalign=1, out_result=0x1002. Without it: dreq_addr=0x1000.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// mem_stage_ctrl : load/store memory stage with byte strobes, load alignment
//                  and a single-entry valid/ready result register.
// Optional macro : MEM_MISALIGN_TRAP_EN (adds out_misalign, skips bus access)
// Revision       : 1.0
// ============================================================================
module mem_stage_ctrl #(
    parameter int XLEN  = 64,
    parameter int REG_W = 5
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     in_pc,
    input  logic [XLEN-1:0]     in_addr,
    input  logic [XLEN-1:0]     in_wdata,
    input  logic                in_is_load,
    input  logic                in_is_store,
    input  logic [1:0]          in_size,
    input  logic                in_unsigned,
    input  logic [REG_W-1:0]    in_dst,
    output logic                dreq_valid,
    output logic [XLEN-1:0]     dreq_addr,
    output logic [1:0]          dreq_size,
    output logic [XLEN/8-1:0]   dreq_strobe,
    output logic [XLEN-1:0]     dreq_data,
    input  logic                dresp_data_ok,
    input  logic [XLEN-1:0]     dresp_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_pc,
    output logic [REG_W-1:0]    out_dst,
    output logic [XLEN-1:0]     out_result,
    output logic                out_is_load
`ifdef MEM_MISALIGN_TRAP_EN
    ,output logic               out_misalign
`endif
);

    localparam int OFF_W = $clog2(XLEN/8);
    localparam int NB    = XLEN/8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_unsigned;
    logic               r_is_load;
    logic [XLEN-1:0]    r_addr;
    logic [XLEN-1:0]    r_pc;
    logic [REG_W-1:0]   r_dst;

    logic [1:0]         w_size;
    logic [OFF_W-1:0]   w_lowmask;
    logic [OFF_W-1:0]   w_off;
    logic [XLEN-1:0]    w_addr_al;
    logic [NB-1:0]      w_lanes;
    logic               w_is_mem;
    logic               w_accept;
    logic               w_trap;
    logic               w_issue;
    logic [XLEN-1:0]    w_shifted;
    logic [XLEN-1:0]    w_mask;
    logic               w_sign;
    logic [XLEN-1:0]    w_load;

    // A 32-bit datapath has no dword access; it degrades to a word.
    assign w_size    = (XLEN == 32 && in_size == 2'd3) ? 2'd2 : in_size;
    assign w_lowmask = OFF_W'((32'd1 << w_size) - 32'd1);
    assign w_off     = in_addr[OFF_W-1:0] & ~w_lowmask;
    assign w_addr_al = {in_addr[XLEN-1:OFF_W], w_off};
    assign w_lanes   = NB'((32'd1 << (32'd1 << w_size)) - 32'd1);
    assign w_is_mem  = in_is_load | in_is_store;

`ifdef MEM_MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign = |(in_addr[OFF_W-1:0] & w_lowmask);
    assign w_trap     = w_is_mem & w_misalign;
`else
    assign w_trap     = 1'b0;
`endif

    assign in_ready = (r_state == IDLE) && (!out_valid || out_ready) && !flush;
    assign w_accept = in_valid && in_ready;
    assign w_issue  = w_is_mem && !w_trap;

    // Load data is realigned using the issued (held) request fields.
    assign w_shifted = dresp_data >> {dreq_addr[OFF_W-1:0], 3'b000};

    always_comb begin
        w_mask = '1;
        w_sign = w_shifted[XLEN-1];
        case (dreq_size)
            2'd0: begin w_mask = XLEN'(8'hFF);         w_sign = w_shifted[7];  end
            2'd1: begin w_mask = XLEN'(16'hFFFF);      w_sign = w_shifted[15]; end
            2'd2: begin w_mask = XLEN'(32'hFFFF_FFFF); w_sign = w_shifted[31]; end
            default: begin w_mask = '1;                w_sign = w_shifted[XLEN-1]; end
        endcase
    end

    assign w_load = (w_shifted & w_mask) | ({XLEN{w_sign & ~r_unsigned}} & ~w_mask);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_unsigned  <= 1'b0;
            r_is_load   <= 1'b0;
            r_addr      <= '0;
            r_pc        <= '0;
            r_dst       <= '0;
            dreq_valid  <= 1'b0;
            dreq_addr   <= '0;
            dreq_size   <= 2'd0;
            dreq_strobe <= '0;
            dreq_data   <= '0;
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_dst     <= '0;
            out_result  <= '0;
            out_is_load <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            out_misalign <= 1'b0;
`endif
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (flush) begin
                        out_valid <= 1'b0;
                    end else if (w_accept) begin
                        if (w_issue) begin
                            r_state     <= BUSY;
                            dreq_valid  <= 1'b1;
                            dreq_addr   <= w_addr_al;
                            dreq_size   <= w_size;
                            dreq_strobe <= in_is_store ? (w_lanes << w_off) : '0;
                            dreq_data   <= in_wdata << {w_off, 3'b000};
                            r_pc        <= in_pc;
                            r_dst       <= in_dst;
                            r_addr      <= in_addr;
                            r_is_load   <= in_is_load;
                            r_unsigned  <= in_unsigned;
                        end else begin
                            out_valid   <= 1'b1;
                            out_pc      <= in_pc;
                            out_dst     <= in_dst;
                            out_result  <= in_addr;
                            out_is_load <= in_is_load;
`ifdef MEM_MISALIGN_TRAP_EN
                            out_misalign <= w_trap;
`endif
                        end
                    end
                end
                BUSY: begin
                    if (dresp_data_ok) begin
                        dreq_valid <= 1'b0;
                        r_state    <= IDLE;
                        // A flush coinciding with completion still discards the result.
                        if (!flush) begin
                            out_valid   <= 1'b1;
                            out_pc      <= r_pc;
                            out_dst     <= r_dst;
                            out_result  <= r_is_load ? w_load : r_addr;
                            out_is_load <= r_is_load;
`ifdef MEM_MISALIGN_TRAP_EN
                            out_misalign <= 1'b0;
`endif
                        end
                    end else if (flush) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (dresp_data_ok) begin
                        dreq_valid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// tb_mem_stage_ctrl : vector table + hand sequences, results checked through a
//                     scoreboard queue popped on every output handshake.
module tb_mem_stage_ctrl;

    localparam int XLEN  = 64;
    localparam int REG_W = 5;

    logic             clk = 1'b0;
    logic             resetn;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_pc;
    logic [63:0]      in_addr;
    logic [63:0]      in_wdata;
    logic             in_is_load;
    logic             in_is_store;
    logic [1:0]       in_size;
    logic             in_unsigned;
    logic [4:0]       in_dst;
    logic             dreq_valid;
    logic [63:0]      dreq_addr;
    logic [1:0]       dreq_size;
    logic [7:0]       dreq_strobe;
    logic [63:0]      dreq_data;
    logic             dresp_data_ok;
    logic [63:0]      dresp_data;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_pc;
    logic [4:0]       out_dst;
    logic [63:0]      out_result;
    logic             out_is_load;
`ifdef MEM_MISALIGN_TRAP_EN
    logic             out_misalign;
`endif

    always #5 clk = ~clk;

    mem_stage_ctrl #(.XLEN(XLEN), .REG_W(REG_W)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_is_load(in_is_load),
        .in_is_store(in_is_store), .in_size(in_size), .in_unsigned(in_unsigned),
        .in_dst(in_dst),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_dst(out_dst), .out_result(out_result), .out_is_load(out_is_load)
`ifdef MEM_MISALIGN_TRAP_EN
        , .out_misalign(out_misalign)
`endif
    );

    typedef struct {
        logic        is_load;
        logic        is_store;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic        req;
        logic [63:0] exp_addr;
        logic [7:0]  exp_strobe;
        logic [63:0] exp_data;
        logic [63:0] exp_result;
        logic        mis;
        int          lat;
    } vec_t;

    typedef struct {
        logic [63:0] pc;
        logic [4:0]  dst;
        logic [63:0] result;
        logic        is_load;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[12];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_op(input logic ld, input logic st, input logic [1:0] sz,
                            input logic uns, input logic [63:0] addr,
                            input logic [63:0] wdata, input logic [63:0] pc,
                            input logic [4:0] dst);
        in_valid    = 1'b1;
        in_is_load  = ld;
        in_is_store = st;
        in_size     = sz;
        in_unsigned = uns;
        in_addr     = addr;
        in_wdata    = wdata;
        in_pc       = pc;
        in_dst      = dst;
    endtask

    task automatic push_exp(input logic [63:0] pc, input logic [4:0] dst,
                            input logic [63:0] res, input logic ld, input logic mis);
        exp_t e;
        e.pc = pc; e.dst = dst; e.result = res; e.is_load = ld; e.mis = mis;
        exp_q.push_back(e);
    endtask

    // Called at a negedge with the stage idle; returns at the negedge the result shows.
    task automatic run_vec(input vec_t v, input int idx);
        logic [63:0] pc;
        logic [4:0]  dst;
        pc  = 64'h8000_0000 + 64'(idx * 4);
        dst = 5'(idx + 1);
        drive_op(v.is_load, v.is_store, v.size, v.uns, v.addr, v.wdata, pc, dst);
        push_exp(pc, dst, v.exp_result, v.is_load, v.mis);
        #1 chk($sformatf("v%0d_in_ready", idx), in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk($sformatf("v%0d_dreq_valid", idx), dreq_valid, v.req);
        if (v.req) begin
            chk($sformatf("v%0d_dreq_size", idx), dreq_size, v.size);
            for (int c = 0; c <= v.lat; c++) begin
                if (c != 0) @(negedge clk);
                chk($sformatf("v%0d_dreq_addr", idx), dreq_addr, v.exp_addr);
                chk($sformatf("v%0d_dreq_strobe", idx), dreq_strobe, v.exp_strobe);
                chk($sformatf("v%0d_dreq_data", idx), dreq_data, v.exp_data);
                chk($sformatf("v%0d_busy_out_valid", idx), out_valid, 0);
            end
            dresp_data_ok = 1'b1;
            dresp_data    = v.rdata;
            @(negedge clk);
            dresp_data_ok = 1'b0;
            dresp_data    = 64'h0;
            chk($sformatf("v%0d_dreq_release", idx), dreq_valid, 0);
        end
        chk($sformatf("v%0d_out_valid", idx), out_valid, 1);
    endtask

    // Scoreboard: every output handshake consumes one expected entry.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (resetn && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got out_result=%h, expected no output", out_result);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_out_pc", out_pc, e.pc);
                    chk("sb_out_dst", out_dst, e.dst);
                    chk("sb_out_result", out_result, e.result);
                    chk("sb_out_is_load", out_is_load, e.is_load);
`ifdef MEM_MISALIGN_TRAP_EN
                    chk("sb_out_misalign", out_misalign, e.mis);
`endif
                end
            end
        end
    end

    initial begin
        resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = 64'h0; in_addr = 64'h0;
        in_wdata = 64'h0; in_is_load = 1'b0; in_is_store = 1'b0; in_size = 2'd0;
        in_unsigned = 1'b0; in_dst = 5'd0; dresp_data_ok = 1'b0; dresp_data = 64'h0;
        out_ready = 1'b1;

        vecs[0]  = '{1'b0, 1'b0, 2'd0, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0, 64'h0,
                     1'b0, 64'h0, 8'h00, 64'h0, 64'h1234_5678_9ABC_DEF0, 1'b0, 0};
        vecs[1]  = '{1'b1, 1'b0, 2'd0, 1'b0, 64'h1003, 64'h0, 64'h0000_0000_8000_0000,
                     1'b1, 64'h1003, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 2};
        vecs[2]  = '{1'b1, 1'b0, 2'd0, 1'b1, 64'h1003, 64'h0, 64'h0000_0000_8000_0000,
                     1'b1, 64'h1003, 8'h00, 64'h0, 64'h0000_0000_0000_0080, 1'b0, 1};
        vecs[3]  = '{1'b0, 1'b1, 2'd1, 1'b0, 64'h1006, 64'hBEEF, 64'h0,
                     1'b1, 64'h1006, 8'hC0, 64'hBEEF_0000_0000_0000, 64'h1006, 1'b0, 3};
        vecs[4]  = '{1'b1, 1'b0, 2'd1, 1'b0, 64'h2002, 64'h0, 64'h0000_0000_8001_0000,
                     1'b1, 64'h2002, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 1'b0, 0};
        vecs[5]  = '{1'b1, 1'b0, 2'd2, 1'b1, 64'h2004, 64'h0, 64'hDEAD_BEEF_0000_0000,
                     1'b1, 64'h2004, 8'h00, 64'h0, 64'h0000_0000_DEAD_BEEF, 1'b0, 1};
        vecs[6]  = '{1'b1, 1'b0, 2'd2, 1'b0, 64'h2004, 64'h0, 64'hDEAD_BEEF_0000_0000,
                     1'b1, 64'h2004, 8'h00, 64'h0, 64'hFFFF_FFFF_DEAD_BEEF, 1'b0, 0};
        vecs[7]  = '{1'b1, 1'b0, 2'd3, 1'b0, 64'h3000, 64'h0, 64'h0123_4567_89AB_CDEF,
                     1'b1, 64'h3000, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0, 2};
        vecs[8]  = '{1'b0, 1'b1, 2'd0, 1'b0, 64'h3005, 64'hAA, 64'h0,
                     1'b1, 64'h3005, 8'h20, 64'h0000_AA00_0000_0000, 64'h3005, 1'b0, 1};
        vecs[9]  = '{1'b0, 1'b1, 2'd2, 1'b0, 64'h3004, 64'hFFFF_FFFF_1122_3344, 64'h0,
                     1'b1, 64'h3004, 8'hF0, 64'h1122_3344_0000_0000, 64'h3004, 1'b0, 0};
        vecs[10] = '{1'b0, 1'b1, 2'd3, 1'b0, 64'h3008, 64'h55, 64'h0,
                     1'b1, 64'h3008, 8'hFF, 64'h55, 64'h3008, 1'b0, 1};
`ifdef MEM_MISALIGN_TRAP_EN
        vecs[11] = '{1'b1, 1'b0, 2'd2, 1'b0, 64'h1002, 64'h0, 64'h0,
                     1'b0, 64'h0, 8'h00, 64'h0, 64'h1002, 1'b1, 0};
`else
        vecs[11] = '{1'b1, 1'b0, 2'd2, 1'b0, 64'h1002, 64'h0, 64'h0000_0000_CAFE_F00D,
                     1'b1, 64'h1000, 8'h00, 64'h0, 64'hFFFF_FFFF_CAFE_F00D, 1'b0, 0};
`endif

        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dreq_valid", dreq_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_dreq_addr", dreq_addr, 0);
        chk("rst_dreq_strobe", dreq_strobe, 0);
        chk("rst_dreq_data", dreq_data, 0);
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], i);
        end
        @(negedge clk);

        // Backpressure: entry A held four cycles, then B accepted with no bubble.
        out_ready = 1'b0;
        drive_op(1'b0, 1'b0, 2'd0, 1'b0, 64'hA1, 64'h0, 64'h100, 5'd10);
        push_exp(64'h100, 5'd10, 64'hA1, 1'b0, 1'b0);
        @(negedge clk);
        drive_op(1'b0, 1'b0, 2'd0, 1'b0, 64'hB2, 64'h0, 64'h104, 5'd11);
        push_exp(64'h104, 5'd11, 64'hB2, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_result", out_result, 64'hA1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_b2b_out_valid", out_valid, 1);
        chk("bp_b2b_out_result", out_result, 64'hB2);
        @(negedge clk);

        // Flush while BUSY: request held, result dropped.
        drive_op(1'b1, 1'b0, 2'd3, 1'b0, 64'h4000, 64'h0, 64'h200, 5'd12);
        @(negedge clk);
        in_valid = 1'b0;
        chk("fb_dreq_valid", dreq_valid, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fb_drain_dreq_valid", dreq_valid, 1);
        chk("fb_drain_dreq_addr", dreq_addr, 64'h4000);
        #1 chk("fb_drain_in_ready", in_ready, 0);
        @(negedge clk);
        chk("fb_drain_out_valid", out_valid, 0);
        dresp_data_ok = 1'b1;
        dresp_data    = 64'h1111_2222_3333_4444;
        @(negedge clk);
        dresp_data_ok = 1'b0;
        chk("fb_done_dreq_valid", dreq_valid, 0);
        chk("fb_done_out_valid", out_valid, 0);
        #1 chk("fb_done_in_ready", in_ready, 1);
        @(negedge clk);

        // Flush in IDLE clears a held entry and blocks a simultaneous input.
        out_ready = 1'b0;
        drive_op(1'b0, 1'b0, 2'd0, 1'b0, 64'hC3, 64'h0, 64'h300, 5'd13);
        @(negedge clk);
        chk("fi_out_valid", out_valid, 1);
        drive_op(1'b0, 1'b0, 2'd0, 1'b0, 64'hD4, 64'h0, 64'h304, 5'd14);
        flush = 1'b1;
        #1 chk("fi_in_ready", in_ready, 0);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fi_cleared", out_valid, 0);
        @(negedge clk);
        chk("fi_no_accept", out_valid, 0);
        out_ready = 1'b1;

        // Stray completion in IDLE is ignored.
        dresp_data_ok = 1'b1;
        @(negedge clk);
        dresp_data_ok = 1'b0;
        chk("idle_ok_out_valid", out_valid, 0);
        chk("idle_ok_dreq_valid", dreq_valid, 0);
        @(negedge clk);

        // Asynchronous reset mid-BUSY.
        drive_op(1'b1, 1'b0, 2'd2, 1'b0, 64'h5000, 64'h0, 64'h400, 5'd15);
        @(negedge clk);
        in_valid = 1'b0;
        chk("ar_dreq_valid", dreq_valid, 1);
        #3 resetn = 1'b0;
        #1;
        chk("ar_dreq_valid_drop", dreq_valid, 0);
        chk("ar_out_valid", out_valid, 0);
        chk("ar_dreq_addr", dreq_addr, 0);
        chk("ar_idle_in_ready", in_ready, 1);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_drain: got %0d pending entries expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
